burst_write_sink: RTL

Memory-side responder for the SPS burst protocol. The burst controller issues one request carrying a start address and a burst length. It then streams data beats, and this block acts as the receiving end. The block accepts each beat with a valid/ready handshake and turns it into a single-word MRAM write, incrementing the address as it goes. It terminates after exactly burst_len + 1 beats, which matches the controller's stop condition, and then pulses a completion flag.

---
 rtl/burst_write_sink_if.sv | 45 ++++
 rtl/burst_write_sink.sv | 127 ++++++++++++
 2 files changed

// File: rtl/burst_write_sink_if.sv
// rtl/burst_write_sink_if.sv - request, beat and memory-write signal bundle for burst_write_sink
//
// Purpose: groups the three handshake/bus groups seen by burst_write_sink.
//   req_*   : burst request (start address, length minus one) with valid/ready
//   in_*    : data beat stream with valid/ready
//   mem_*   : single-word memory write port (mem_busy back-pressures new beats)
// Modports:
//   master : controller/memory side (drives requests, beats and mem_busy)
//   slave  : burst_write_sink side

interface burst_write_sink_if #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int COUNTER_WIDTH = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic [ADDR_WIDTH-1:0]    req_addr;
    logic [COUNTER_WIDTH-1:0] req_burst_len;

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    in_data;

    logic                     mem_busy;
    logic                     mem_we;
    logic [ADDR_WIDTH-1:0]    mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;

    modport master (
        output req_valid, req_addr, req_burst_len,
        output in_valid, in_data,
        output mem_busy,
        input  req_ready, in_ready,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_addr, req_burst_len,
        input  in_valid, in_data,
        input  mem_busy,
        output req_ready, in_ready,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/burst_write_sink.sv
// rtl/burst_write_sink.sv - burst responder turning a stream of beats into single-word memory writes
//
// Purpose: accepts one burst request (start address + length-1), then accepts
// exactly length+1 data beats, issuing one registered memory write per beat at
// an auto-incrementing (wrapping) address, and pulses done at completion.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : burst_write_sink_if.slave (request, beat stream, memory write port)
//   beat_count : beats accepted in the current/last burst
//   busy       : burst in progress (ACTIVE or DONE)
//   done       : one-cycle completion pulse, coincides with the final write

module burst_write_sink #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    burst_write_sink_if.slave      bus,
    output logic [COUNTER_WIDTH:0] beat_count,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [COUNTER_WIDTH:0] CNT_ONE  = (COUNTER_WIDTH+1)'(1);

    state_t                   state;
    state_t                   state_next;

    logic [ADDR_WIDTH-1:0]    ptr;
    logic [COUNTER_WIDTH-1:0] len_q;
    logic [COUNTER_WIDTH:0]   count_q;
    logic                     ready_q;
    logic                     we_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;

    logic                     in_ready_c;
    logic                     req_fire;
    logic                     beat_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready_c = 1'b0;
        req_fire   = 1'b0;
        beat_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    req_fire   = 1'b1;
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                in_ready_c = !bus.mem_busy;
                if (bus.in_valid && in_ready_c) begin
                    beat_fire = 1'b1;
                    // Extra counter bit keeps len = all-ones from wrapping.
                    if (count_q == {1'b0, len_q}) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // req_ready is registered so it stays low through the reset-release cycle
    // and rises only after the first clock edge spent in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr     <= '0;
            len_q   <= '0;
            count_q <= '0;
        end else begin
            ready_q <= (state_next == ST_IDLE);
            we_q    <= beat_fire;
            if (req_fire) begin
                ptr     <= bus.req_addr;
                len_q   <= bus.req_burst_len;
                count_q <= '0;
            end
            if (beat_fire) begin
                addr_q  <= ptr;
                wdata_q <= bus.in_data;
                ptr     <= ptr + ADDR_ONE;
                count_q <= count_q + CNT_ONE;
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.in_ready  = in_ready_c;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign beat_count    = count_q;
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);

endmodule
